// File: rtl/onchip_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : onchip_ram_pkg
// Description : Shared definitions for the on-chip RAM port controller:
//               controller state encoding, default RAM geometry and the
//               packed layout of a response-FIFO entry.
// Revision    : 1.0 - initial release
// ============================================================================
package onchip_ram_pkg;

    // Default geometry of the 256x16 block RAM
    localparam int c_DEF_ADDR_W = 8;
    localparam int c_DEF_DATA_W = 16;

    // Controller states
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    // Response entry layout {wr, rdata}. The controller packs its FIFO words
    // in this same order (wr flag above the data) for any DATA_W.
    typedef struct packed {
        logic                    wr;
        logic [c_DEF_DATA_W-1:0] rdata;
    } rsp_entry_t;

endpackage : onchip_ram_pkg
`default_nettype wire

// File: rtl/onchip_ram_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : onchip_ram_rsp_fifo
// Description : Synchronous first-word-fall-through FIFO. A word pushed at an
//               edge is presented on o_data (with o_empty low) in the next
//               cycle. Push and pop in the same cycle are allowed, also when
//               full.
// Ports       : clk, rst    - clock, synchronous active-high reset (flush)
//               i_push/i_data - write strobe and word
//               i_pop        - consume the head word
//               o_data       - head word (valid while o_empty is low)
//               o_full/o_empty - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module onchip_ram_rsp_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_wr_en;
    logic               w_rd_en;

    assign o_full  = (r_count == c_FULL);
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    assign w_rd_en = i_pop & ~o_empty;
    // A pop frees the head slot in the same edge, so a full FIFO still takes
    // a simultaneous push.
    assign w_wr_en = i_push & (~o_full | w_rd_en);

    // Storage needs no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            unique case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : onchip_ram_rsp_fifo
`default_nettype wire

// File: rtl/onchip_ram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : onchip_ram_port_ctrl
// Description : Initiator-side controller for one port of the on-chip block
//               RAM. Turns a valid/ready request stream into registered RAM
//               port cycles, tracks the fixed read latency and returns read
//               data in request order through a FWFT response FIFO. After
//               reset it can sweep INIT_VAL into every address before
//               accepting traffic.
// Option      : ONCHIP_RAM_WR_ACK_EN - writes consume a credit and return a
//               response (o_rsp_wr=1, o_rsp_rdata=0) at read latency.
// Ports       : i_sys_clk, i_rst          - clock, sync active-high reset
//               i_req_*  / o_req_ready    - request stream
//               o_rsp_*  / i_rsp_ready    - response stream
//               o_ram_*  / i_ram_dout     - RAM port A
//               o_init_done               - sweep finished, operational
// Revision    : 1.0 - initial release
// ============================================================================
module onchip_ram_port_ctrl
    import onchip_ram_pkg::*;
#(
    parameter int                ADDR_W     = c_DEF_ADDR_W,
    parameter int                DATA_W     = c_DEF_DATA_W,
    parameter int                RD_LAT     = 1,
    parameter int                RSP_DEPTH  = 4,
    parameter int                INIT_CLEAR = 1,
    parameter logic [DATA_W-1:0] INIT_VAL   = '0
) (
    input  logic              i_sys_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_wr,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_din,
    input  logic [DATA_W-1:0] i_ram_dout,
    output logic              o_init_done
);

    localparam int c_OUT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [c_OUT_W-1:0] c_CREDITS    = c_OUT_W'(RSP_DEPTH);
    localparam logic [ADDR_W-1:0]  c_SWEEP_LAST = '1;
    localparam state_t c_RST_STATE = (INIT_CLEAR != 0) ? ST_INIT : ST_IDLE;
`ifdef ONCHIP_RAM_WR_ACK_EN
    localparam int c_RSP_W = DATA_W + 1;
`else
    localparam int c_RSP_W = DATA_W;
`endif

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_sweep;
    logic [ADDR_W-1:0]   w_sweep_next;

    logic                r_ram_en;
    logic                r_ram_we;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_din;
    logic                w_ram_en_next;
    logic                w_ram_we_next;
    logic [ADDR_W-1:0]   w_ram_addr_next;
    logic [DATA_W-1:0]   w_ram_din_next;

    // Set alongside a RAM cycle that must produce a response
    logic                r_ram_rsp;
    logic [RD_LAT-1:0]   r_rsp_pipe;

    logic [c_OUT_W-1:0]  r_outstanding;
    logic                w_credit;
    logic                w_accept;
    logic                w_credit_take;
    logic                w_pop;
    logic                w_push;
    logic [c_RSP_W-1:0]  w_push_data;
    logic [c_RSP_W-1:0]  w_head;
    logic                w_fifo_full;
    logic                w_fifo_empty;

    // ------------------------------------------------------------------
    // Request acceptance. Credits are judged on the registered count, so
    // a pop in this cycle only frees a credit from the next cycle on.
    // ------------------------------------------------------------------
    assign w_credit = (r_outstanding < c_CREDITS);
    assign w_accept = i_req_valid & o_req_ready;
    assign w_pop    = o_rsp_valid & i_rsp_ready;

`ifdef ONCHIP_RAM_WR_ACK_EN
    logic                r_ram_rsp_wr;
    logic [RD_LAT-1:0]   r_wr_pipe;

    assign o_req_ready   = ~i_rst & (r_state == ST_IDLE) & w_credit;
    assign w_credit_take = w_accept;
    assign w_push_data   = {r_wr_pipe[RD_LAT-1],
                            r_wr_pipe[RD_LAT-1] ? {DATA_W{1'b0}} : i_ram_dout};
    assign o_rsp_rdata   = w_head[DATA_W-1:0];
    assign o_rsp_wr      = w_head[DATA_W];
`else
    assign o_req_ready   = ~i_rst & (r_state == ST_IDLE) & (i_req_we | w_credit);
    assign w_credit_take = w_accept & ~i_req_we;
    assign w_push_data   = i_ram_dout;
    assign o_rsp_rdata   = w_head;
    assign o_rsp_wr      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM next state and RAM port next values
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_sweep_next    = r_sweep;
        w_ram_en_next   = 1'b0;
        w_ram_we_next   = 1'b0;
        w_ram_addr_next = r_ram_addr;
        w_ram_din_next  = r_ram_din;
        unique case (r_state)
            ST_INIT: begin
                w_ram_en_next   = 1'b1;
                w_ram_we_next   = 1'b1;
                w_ram_addr_next = r_sweep;
                w_ram_din_next  = INIT_VAL;
                w_sweep_next    = r_sweep + 1'b1;
                if (r_sweep == c_SWEEP_LAST) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_accept) begin
                    w_ram_en_next   = 1'b1;
                    w_ram_we_next   = i_req_we;
                    w_ram_addr_next = i_req_addr;
                    w_ram_din_next  = i_req_wdata;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_state       <= c_RST_STATE;
            r_sweep       <= '0;
            r_ram_en      <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_din     <= '0;
            r_ram_rsp     <= 1'b0;
            r_rsp_pipe    <= '0;
            r_outstanding <= '0;
        end else begin
            r_state    <= w_state_next;
            r_sweep    <= w_sweep_next;
            r_ram_en   <= w_ram_en_next;
            r_ram_we   <= w_ram_we_next;
            r_ram_addr <= w_ram_addr_next;
            r_ram_din  <= w_ram_din_next;
            r_ram_rsp  <= w_credit_take;

            // Valid bit follows the RAM cycle; its tail lines up with dout.
            r_rsp_pipe[0] <= r_ram_rsp;
            for (int k = 1; k < RD_LAT; k++) begin
                r_rsp_pipe[k] <= r_rsp_pipe[k-1];
            end

            unique case ({w_credit_take, w_pop})
                2'b10:   r_outstanding <= r_outstanding + c_OUT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - c_OUT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

`ifdef ONCHIP_RAM_WR_ACK_EN
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_ram_rsp_wr <= 1'b0;
            r_wr_pipe    <= '0;
        end else begin
            r_ram_rsp_wr <= w_accept & i_req_we;
            r_wr_pipe[0] <= r_ram_rsp_wr;
            for (int k = 1; k < RD_LAT; k++) begin
                r_wr_pipe[k] <= r_wr_pipe[k-1];
            end
        end
    end
`endif

    assign w_push = r_rsp_pipe[RD_LAT-1];

    // ------------------------------------------------------------------
    // Response buffer. Outstanding credits cover both in-flight reads and
    // buffered words, so the FIFO can never be pushed while full.
    // ------------------------------------------------------------------
    onchip_ram_rsp_fifo #(
        .WIDTH (c_RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (i_sys_clk),
        .rst     (i_rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst) begin
            assert (!(w_push && w_fifo_full));
        end
    end

    assign o_rsp_valid = ~w_fifo_empty;
    assign o_ram_en    = r_ram_en;
    assign o_ram_we    = r_ram_we;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_din   = r_ram_din;
    assign o_init_done = (r_state == ST_IDLE);

endmodule : onchip_ram_port_ctrl
`default_nettype wire

// File: tb/tb_onchip_ram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_onchip_ram_port_ctrl
// Description : Self-checking bench for onchip_ram_port_ctrl with a 256x16
//               single-cycle-latency RAM model. Expected responses come from
//               a shadow memory and are queued at request acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onchip_ram_port_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_wr;
    logic        ram_en;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic        init_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    logic [15:0] mem    [256];
    logic [15:0] shadow [256];
    logic [16:0] sb_q   [$];
    logic [16:0] sb_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    onchip_ram_port_ctrl dut (
        .i_sys_clk   (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_we    (req_we),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_wr    (rsp_wr),
        .o_ram_en    (ram_en),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_din   (ram_din),
        .i_ram_dout  (ram_dout),
        .o_init_done (init_done)
    );

    // RAM model: read-first, one cycle latency
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 16'hDEAD ^ 16'(i);
            shadow[i] = 16'h0000;
        end
        ram_dout = 16'h0000;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            ram_dout <= mem[ram_addr];
            if (ram_we) mem[ram_addr] <= ram_din;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare responses first, then queue new expectations
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    sb_e = sb_q.pop_front();
                    check("rsp_rdata", 32'(rsp_rdata), 32'(sb_e[15:0]));
                    check("rsp_wr", 32'(rsp_wr), 32'(sb_e[16]));
                end
            end
            if (req_valid && req_ready) begin
                if (req_we) begin
                    shadow[req_addr] = req_wdata;
`ifdef ONCHIP_RAM_WR_ACK_EN
                    sb_q.push_back({1'b1, 16'h0000});
`endif
                end else begin
                    sb_q.push_back({1'b0, shadow[req_addr]});
                end
            end
        end
    end

    task automatic send(input logic we, input logic [7:0] addr, input logic [15:0] data,
                        output int waits);
        logic acc;
        acc   = 1'b0;
        waits = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        while (!acc && waits < 200) begin
            @(negedge clk);
            acc = req_ready;
            if (acc) acc_cyc = cyc;
            @(posedge clk);
            #1;
            if (!acc) waits++;
        end
        req_valid = 1'b0;
        check("req_accept", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, w, stalls, acc, stale, nz, found;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: init sweep
        n = 0; w = 0;
        while (n < 400) begin
            @(negedge clk);
            if (init_done) break;
            if (req_ready) w = 1;
            @(posedge clk);
            n++;
        end
        check("init_cycles", 32'(n), 32'd256);
        check("init_ready_low", 32'(w), 32'd0);
        @(posedge clk); #1;
        nz = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== 16'h0000) nz++;
        check("init_mem_clear", 32'(nz), 32'd0);

        // 2: write then read, latency
        rsp_ready = 1'b1;
        send(1'b1, 8'h10, 16'hA5A5, w);
        send(1'b0, 8'h10, 16'h0000, w);
        n = 0; found = 0;
        while (n < 20 && found == 0) begin
            @(negedge clk);
            if (rsp_valid) found = 1;
            else begin @(posedge clk); n++; end
        end
        check("rd_found", 32'(found), 32'd1);
        check("rd_latency", 32'(cyc - acc_cyc), 32'd3);
        check("rd_data", 32'(rsp_rdata), 32'hA5A5);
        @(posedge clk); #1;
        drain();

        // 3: fill and back-to-back readback
        for (int k = 0; k < 256; k++) send(1'b1, 8'(k), 16'(k), w);
        stalls = 0;
        for (int k = 0; k < 256; k++) begin
            send(1'b0, 8'(k), 16'h0000, w);
            stalls += w;
        end
        check("b2b_stalls", 32'(stalls), 32'd0);
        drain();

        // 4: backpressure limits outstanding reads to the FIFO depth
        rsp_ready = 1'b0;
        acc = 0;
        req_valid = 1'b1; req_we = 1'b0;
        for (int i = 0; i < 12 && acc < 6; i++) begin
            req_addr = 8'(20 + acc);
            @(negedge clk);
            if (req_ready) acc++;
            @(posedge clk); #1;
        end
        check("bp_accepted", 32'(acc), 32'd4);
        @(negedge clk);
        check("bp_ready_low", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();
        @(negedge clk);
        check("bp_ready_back", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // 5: reset with two reads in flight and one buffered
        rsp_ready = 1'b0;
        send(1'b0, 8'd1, 16'h0, w);
        send(1'b0, 8'd2, 16'h0, w);
        send(1'b0, 8'd3, 16'h0, w);
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("pre_rst_buffered", 32'(rsp_valid), 32'd1);
        stale = 0;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            if (rsp_valid) stale++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 256; i++) shadow[i] = 16'h0000;
        @(posedge clk); @(negedge clk);
        check("sweep_restart_addr", 32'(ram_addr), 32'd0);
        check("sweep_restart_en", 32'({ram_en, ram_we}), 32'd3);
        n = 0;
        while (!init_done && n < 400) begin
            @(posedge clk); @(negedge clk);
            if (rsp_valid) stale++;
            n++;
        end
        check("post_rst_stale", 32'(stale), 32'd0);
        check("post_rst_done", 32'(init_done), 32'd1);
        @(posedge clk); #1;

        // 6: write, read, write (acks only when the option is built in)
        send(1'b1, 8'h30, 16'h1234, w);
        send(1'b0, 8'h30, 16'h0000, w);
        send(1'b1, 8'h31, 16'h5678, w);
        drain();
        repeat (5) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_onchip_ram_port_ctrl
`default_nettype wire
